// File: rtl/set_readback_pkg.sv
// set_readback_pkg: shared encodings and constants for the CPLD settings register blocks.
package set_readback_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;
  localparam int SCCFAST = 6;
  localparam int VIASLOW = 5;
  localparam int IWMSLOW = 4;
  localparam int SNDSLOW = 3;
  localparam int SNDCLKGATE = 2;
  localparam int CLKGATE = 1;
  localparam int SLOW = 0;
  localparam logic [6:0] SET_RESET_IMAGE = 7'h7C;
  localparam logic [7:0] DEFAULT_ID_BYTE = 8'h5A;
endpackage

// File: rtl/set_dirty_track.sv
// set_dirty_track: sticky flag raised on any settings change, cleared by a completed read.
// A change on the clearing edge keeps the flag set so it is never lost.
module set_dirty_track
  import set_readback_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_settings,
  input  logic       i_clear,
  output logic       o_dirty
);
  logic [6:0] r_set_prev;
  logic       r_dirty;
  logic       w_change;
  assign w_change = i_settings != r_set_prev;
  assign o_dirty  = r_dirty;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_set_prev <= SET_RESET_IMAGE;
      r_dirty    <= 1'b1;
    end else begin
      r_set_prev <= i_settings;
      r_dirty    <= w_change ? 1'b1 : i_clear ? 1'b0 : r_dirty;
    end
  end
endmodule

// File: rtl/set_readback.sv
// set_readback: read-side responder returning {ID, settings snapshot, dirty} on a settings read cycle.
module set_readback
  import set_readback_pkg::*;
#(
  parameter int         WAIT_CYCLES = 2,
  parameter logic [7:0] ID_BYTE     = DEFAULT_ID_BYTE
) (
  input  logic        CLK,
  input  logic        POR,
  input  logic        BACT,
  input  logic        SetCSRD,
  input  logic [6:0]  Settings,
  output logic [15:0] D,
  output logic        DOE,
  output logic        SetRdAck,
  output logic        Busy
);
  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("set_readback: WAIT_CYCLES must be in 1..15");
    end
  endgenerate
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic [6:0]  r_snap;
  logic        r_snap_dirty;
  logic [15:0] r_d;
  logic        r_doe;
  logic        r_ack;
  logic        w_capture;
  logic        w_clear;
  logic        w_drive;
  logic        w_dirty;
  set_dirty_track u_dirty (
    .i_clk      (CLK),
    .i_rst      (POR),
    .i_settings (Settings),
    .i_clear    (w_clear),
    .o_dirty    (w_dirty)
  );
  always_ff @(posedge CLK or posedge POR) begin
    if (POR) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_IDLE: if (BACT && SetCSRD) begin
        w_state_next = ST_WAIT;
        w_cnt_next   = WAIT_LOAD;
        w_capture    = 1'b1;
      end
      ST_WAIT: if (!BACT) w_state_next = ST_IDLE;
        else if (r_cnt == 4'd0) w_state_next = ST_DRIVE;
        else w_cnt_next = r_cnt - 4'd1;
      ST_DRIVE: begin
        w_state_next = ST_HOLD;
        w_clear      = 1'b1;
      end
      ST_HOLD: if (!BACT) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    w_drive = (r_state == ST_DRIVE) || (r_state == ST_HOLD && BACT);
  end
  // Outputs register off the current state, so the bus sees data one edge after DRIVE.
  always_ff @(posedge CLK or posedge POR) begin
    if (POR) begin
      r_snap       <= '0;
      r_snap_dirty <= 1'b0;
      r_d          <= '0;
      r_doe        <= 1'b0;
      r_ack        <= 1'b0;
    end else begin
      if (w_capture) begin
        r_snap       <= Settings;
        r_snap_dirty <= w_dirty;
      end
      r_d   <= w_drive ? {ID_BYTE, r_snap, r_snap_dirty} : 16'h0000;
      r_doe <= w_drive;
      r_ack <= w_drive;
    end
  end
  assign D        = r_d;
  assign DOE      = r_doe;
  assign SetRdAck = r_ack;
  assign Busy     = r_state != ST_IDLE;
endmodule

// File: tb/tb_set_readback.sv
// tb_set_readback: directed read/abort/reset vectors with hand-computed readback values.
module tb_set_readback;
  logic        clk = 1'b0;
  logic        por = 1'b1;
  logic        bact = 1'b0;
  logic        cs = 1'b0;
  logic [6:0]  settings = 7'h7C;
  logic [15:0] d;
  logic        doe;
  logic        ack;
  logic        busy;
  int          total = 0;
  int          bad = 0;
  set_readback dut (
    .CLK      (clk),
    .POR      (por),
    .BACT     (bact),
    .SetCSRD  (cs),
    .Settings (settings),
    .D        (d),
    .DOE      (doe),
    .SetRdAck (ack),
    .Busy     (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic do_read(input string tag, input logic [15:0] exp, input bit mid_en, input logic [6:0] mid_set);
    @(negedge clk);
    bact = 1'b1;
    cs   = 1'b1;
    @(posedge clk) #1;
    chk({tag, " busy_dec"}, 16'(busy), 16'd1);
    chk({tag, " ack_e0"}, 16'(ack), 16'd0);
    @(posedge clk) #1;
    chk({tag, " ack_e1"}, 16'(ack), 16'd0);
    @(posedge clk) #1;
    chk({tag, " ack_e2"}, 16'(ack), 16'd0);
    chk({tag, " doe_e2"}, 16'(doe), 16'd0);
    if (mid_en) settings = mid_set;
    @(posedge clk) #1;
    chk({tag, " ack_e3"}, 16'(ack), 16'd1);
    chk({tag, " doe_e3"}, 16'(doe), 16'd1);
    chk({tag, " d_e3"}, d, exp);
    cs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " d_hold"}, d, exp);
    chk({tag, " ack_hold"}, 16'(ack), 16'd1);
    bact = 1'b0;
    @(posedge clk) #1;
    chk({tag, " doe_end"}, 16'(doe), 16'd0);
    chk({tag, " ack_end"}, 16'(ack), 16'd0);
    chk({tag, " d_end"}, d, 16'h0000);
    chk({tag, " busy_end"}, 16'(busy), 16'd0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_d", d, 16'h0000);
    chk("rst_doe", 16'(doe), 16'd0);
    chk("rst_ack", 16'(ack), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    por = 1'b0;
    do_read("rd1", 16'h5AF9, 1'b0, 7'h00);
    do_read("rd2", 16'h5AF8, 1'b0, 7'h00);
    @(negedge clk);
    settings = 7'h01;
    repeat (2) @(negedge clk);
    do_read("chg1", 16'h5A03, 1'b0, 7'h00);
    do_read("chg2", 16'h5A02, 1'b0, 7'h00);
    @(negedge clk);
    settings = 7'h02;
    repeat (2) @(negedge clk);
    bact = 1'b1;
    cs   = 1'b1;
    @(posedge clk) #1;
    chk("abort_busy", 16'(busy), 16'd1);
    @(posedge clk) #1;
    chk("abort_ack_e1", 16'(ack), 16'd0);
    bact = 1'b0;
    cs   = 1'b0;
    @(posedge clk) #1;
    chk("abort_ack", 16'(ack), 16'd0);
    chk("abort_doe", 16'(doe), 16'd0);
    chk("abort_busy_end", 16'(busy), 16'd0);
    repeat (2) @(posedge clk);
    chk("abort_doe_late", 16'(doe), 16'd0);
    do_read("post_abort", 16'h5A05, 1'b0, 7'h00);
    do_read("mid_chg", 16'h5A04, 1'b1, 7'h03);
    do_read("after_mid", 16'h5A07, 1'b0, 7'h00);
    @(negedge clk);
    bact = 1'b1;
    cs   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_por_doe", 16'(doe), 16'd1);
    #3;
    por = 1'b1;
    #1;
    chk("por_doe", 16'(doe), 16'd0);
    chk("por_ack", 16'(ack), 16'd0);
    chk("por_busy", 16'(busy), 16'd0);
    chk("por_d", d, 16'h0000);
    settings = 7'h7C;
    bact = 1'b0;
    cs   = 1'b0;
    @(negedge clk);
    por = 1'b0;
    do_read("post_por", 16'h5AF9, 1'b0, 7'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
